// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one async-FIFO write port between NREQ
//   valid/ready producers in the wclk domain. Each grant carries a burst of
//   up to MAX_BURST beats. Every pushed beat is tagged {src_id, payload} so
//   the read side can demultiplex it. A grant whose owner goes quiet for
//   TIMEOUT cycles is released. FIFO full stalls the burst without losing
//   the grant.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                   wclk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_push,
  output logic [IDW+DATA_W-1:0]  fifo_din,
  output logic [NREQ-1:0]        grant,
  output logic                   busy
);

  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [NREQ-1:0] grant_q;
  logic [BCW-1:0]  beat_cnt_q;
  logic [TCW-1:0]  idle_cnt_q;
  logic            busy_q;

  logic            any_valid_s;
  logic [IDW-1:0]  owner_d;
  logic [IDW-1:0]  rr_ptr_d;
  logic            burst_end_s;
  logic            timeout_s;
  logic            release_s;

  // First valid requester at or above ptr, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Arbitration choice for the next grant and the pointer after the current owner.
  always_comb begin
    any_valid_s = |req_valid;
    owner_d     = rr_pick(req_valid, rr_ptr_q);
    rr_ptr_d    = IDW'((int'(owner_q) + 1) % NREQ);
  end

  // Write-port datapath and handshake, driven from the registered owner.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    fifo_push = 1'b0;
    fifo_din  = {(IDW+DATA_W){1'b0}};
    if (state_q == S_BURST) begin
      req_ready[owner_q] = ~fifo_full;
      fifo_push          = req_valid[owner_q] & ~fifo_full;
      fifo_din           = {owner_q, req_data[int'(owner_q)*DATA_W +: DATA_W]};
    end else begin
      req_ready = {NREQ{1'b0}};
      fifo_push = 1'b0;
      fifo_din  = {(IDW+DATA_W){1'b0}};
    end
  end

  // Grant release: packet end, burst limit, or owner idle too long.
  always_comb begin
    burst_end_s = req_last[owner_q] | (beat_cnt_q == BCW'(MAX_BURST - 1));
    timeout_s   = (idle_cnt_q == TCW'(TIMEOUT - 1));
    release_s   = 1'b0;
    if (state_q == S_BURST) begin
      release_s = (fifo_push & burst_end_s) |
                  (~fifo_full & ~req_valid[owner_q] & timeout_s);
    end else begin
      release_s = 1'b0;
    end
  end

  // Arbiter FSM with registered grant and busy outputs.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= {IDW{1'b0}};
      rr_ptr_q   <= {IDW{1'b0}};
      grant_q    <= {NREQ{1'b0}};
      beat_cnt_q <= {BCW{1'b0}};
      idle_cnt_q <= {TCW{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid_s) begin
            state_q    <= S_BURST;
            owner_q    <= owner_d;
            grant_q    <= {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
            beat_cnt_q <= {BCW{1'b0}};
            idle_cnt_q <= {TCW{1'b0}};
            busy_q     <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            grant_q <= {NREQ{1'b0}};
            busy_q  <= 1'b0;
          end
        end
        S_BURST: begin
          if (release_s) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= {NREQ{1'b0}};
            beat_cnt_q <= {BCW{1'b0}};
            idle_cnt_q <= {TCW{1'b0}};
            busy_q     <= 1'b0;
          end else if (fifo_push) begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
            idle_cnt_q <= {TCW{1'b0}};
          end else if (!fifo_full) begin
            idle_cnt_q <= idle_cnt_q + TCW'(1);
          end else begin
            // FIFO full: stall with grant and counters frozen
            beat_cnt_q <= beat_cnt_q;
            idle_cnt_q <= idle_cnt_q;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          grant_q    <= {NREQ{1'b0}};
          beat_cnt_q <= {BCW{1'b0}};
          idle_cnt_q <= {TCW{1'b0}};
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with default parameters
//   (4 requesters, 8-bit payload, bursts of 4, timeout 8).
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_push;
  logic [9:0]  fifo_din;
  logic [3:0]  grant;
  logic        busy;

  int n_tests;
  int n_fail;

  fifo_wr_arbiter #(
    .NREQ(4), .DATA_W(8), .IDW(2), .MAX_BURST(4), .TIMEOUT(8)
  ) dut (
    .wclk      (wclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .grant     (grant),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge, then settle before sampling.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d);
    @(negedge wclk);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    req_data  = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    fifo_full = 1'b0;
    req_data  = 32'h0;
    @(negedge wclk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] id;
    logic [3:0] g_exp;
    logic [9:0] din_exp;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    fifo_full = 1'b0;
    req_data  = 32'h0;
    #2;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_push",  32'(fifo_push), 32'h0);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_din",   32'(fifo_din), 32'h0);
    check_eq("rst_busy",  32'(busy), 32'h0);
    @(negedge wclk);
    rst = 1'b1;

    // 1: req0 alone, three beats, last on the third
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_00A0);
    check_eq("t1_arb_grant", 32'(grant), 32'h0);
    check_eq("t1_arb_push",  32'(fifo_push), 32'h0);
    check_eq("t1_arb_ready", 32'(req_ready), 32'h0);
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_00A0);
    check_eq("t1_b0_grant", 32'(grant), 32'h1);
    check_eq("t1_b0_busy",  32'(busy), 32'h1);
    check_eq("t1_b0_ready", 32'(req_ready), 32'h1);
    check_eq("t1_b0_push",  32'(fifo_push), 32'h1);
    check_eq("t1_b0_din",   32'(fifo_din), 32'h0A0);
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_00A1);
    check_eq("t1_b1_push",  32'(fifo_push), 32'h1);
    check_eq("t1_b1_din",   32'(fifo_din), 32'h0A1);
    drive(4'b0001, 4'b0001, 1'b0, 32'h0000_00A2);
    check_eq("t1_b2_push",  32'(fifo_push), 32'h1);
    check_eq("t1_b2_din",   32'(fifo_din), 32'h0A2);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_eq("t1_end_grant", 32'(grant), 32'h0);
    check_eq("t1_end_busy",  32'(busy), 32'h0);
    check_eq("t1_end_push",  32'(fifo_push), 32'h0);

    // 2: all four stream without last; grants rotate 0,1,2,3,0
    do_reset();
    for (int g = 0; g < 5; g++) begin
      id    = 2'(g % 4);
      g_exp = 4'b0001 << id;
      din_exp = {id, 8'hC0 | {6'b000000, id}};
      drive(4'b1111, 4'b0000, 1'b0, 32'hC3C2_C1C0);
      check_eq($sformatf("t2_gap%0d_grant", g), 32'(grant), 32'h0);
      check_eq($sformatf("t2_gap%0d_push", g),  32'(fifo_push), 32'h0);
      for (int b = 0; b < 4; b++) begin
        drive(4'b1111, 4'b0000, 1'b0, 32'hC3C2_C1C0);
        check_eq($sformatf("t2_g%0d_b%0d_grant", g, b), 32'(grant), 32'(g_exp));
        check_eq($sformatf("t2_g%0d_b%0d_push", g, b),  32'(fifo_push), 32'h1);
        check_eq($sformatf("t2_g%0d_b%0d_din", g, b),   32'(fifo_din), 32'(din_exp));
      end
    end
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_eq("t2_end_grant", 32'(grant), 32'h0);

    // 3: FIFO full for 5 cycles after beat 2 of a 4-beat burst
    do_reset();
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_0031);
    check_eq("t3_arb_grant", 32'(grant), 32'h0);
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_0031);
    check_eq("t3_b1_din", 32'(fifo_din), 32'h031);
    check_eq("t3_b1_push", 32'(fifo_push), 32'h1);
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_0032);
    check_eq("t3_b2_din", 32'(fifo_din), 32'h032);
    for (int s = 0; s < 5; s++) begin
      drive(4'b0001, 4'b0000, 1'b1, 32'h0000_0033);
      check_eq($sformatf("t3_stall%0d_push", s),  32'(fifo_push), 32'h0);
      check_eq($sformatf("t3_stall%0d_ready", s), 32'(req_ready), 32'h0);
      check_eq($sformatf("t3_stall%0d_grant", s), 32'(grant), 32'h1);
    end
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_0033);
    check_eq("t3_b3_push", 32'(fifo_push), 32'h1);
    check_eq("t3_b3_din",  32'(fifo_din), 32'h033);
    drive(4'b0001, 4'b0000, 1'b0, 32'h0000_0034);
    check_eq("t3_b4_push",  32'(fifo_push), 32'h1);
    check_eq("t3_b4_din",   32'(fifo_din), 32'h034);
    check_eq("t3_b4_grant", 32'(grant), 32'h1);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_eq("t3_end_grant", 32'(grant), 32'h0);

    // 4: req1 sends one beat then goes quiet; grant times out after 8 idle cycles
    drive(4'b0010, 4'b0000, 1'b0, 32'h0000_E100);
    check_eq("t4_arb_grant", 32'(grant), 32'h0);
    drive(4'b0010, 4'b0000, 1'b0, 32'h0000_E100);
    check_eq("t4_b0_grant", 32'(grant), 32'h2);
    check_eq("t4_b0_din",   32'(fifo_din), 32'h1E1);
    for (int i = 0; i < 8; i++) begin
      drive(4'b0000, 4'b0000, 1'b0, 32'h0);
      check_eq($sformatf("t4_idle%0d_grant", i), 32'(grant), 32'h2);
      check_eq($sformatf("t4_idle%0d_push", i),  32'(fifo_push), 32'h0);
    end

    // 6: rr_ptr now 2 with req1 and req3 valid: req3 first, then req1
    drive(4'b1010, 4'b1010, 1'b0, 32'hF300_F100);
    check_eq("t4_released_grant", 32'(grant), 32'h0);
    check_eq("t4_released_busy",  32'(busy), 32'h0);
    drive(4'b1010, 4'b1010, 1'b0, 32'hF300_F100);
    check_eq("t6_first_grant", 32'(grant), 32'h8);
    check_eq("t6_first_ready", 32'(req_ready), 32'h8);
    check_eq("t6_first_din",   32'(fifo_din), 32'h3F3);
    drive(4'b0010, 4'b0010, 1'b0, 32'h0000_F100);
    check_eq("t6_gap_grant", 32'(grant), 32'h0);
    drive(4'b0010, 4'b0010, 1'b0, 32'h0000_F100);
    check_eq("t6_second_grant", 32'(grant), 32'h2);
    check_eq("t6_second_din",   32'(fifo_din), 32'h1F1);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_eq("t6_end_grant", 32'(grant), 32'h0);

    // 5: rst pulse during beat 2 of a req2 burst; arbitration restarts at req0
    drive(4'b0101, 4'b0000, 1'b0, 32'h0052_0050);
    check_eq("t5_arb_grant", 32'(grant), 32'h0);
    drive(4'b0101, 4'b0000, 1'b0, 32'h0052_0050);
    check_eq("t5_b1_grant", 32'(grant), 32'h4);
    check_eq("t5_b1_din",   32'(fifo_din), 32'h252);
    drive(4'b0101, 4'b0000, 1'b0, 32'h0052_0050);
    check_eq("t5_b2_push", 32'(fifo_push), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("t5_rst_push",  32'(fifo_push), 32'h0);
    check_eq("t5_rst_ready", 32'(req_ready), 32'h0);
    check_eq("t5_rst_grant", 32'(grant), 32'h0);
    check_eq("t5_rst_din",   32'(fifo_din), 32'h0);
    check_eq("t5_rst_busy",  32'(busy), 32'h0);
    @(negedge wclk);
    rst = 1'b1;
    #1;
    check_eq("t5_post_grant", 32'(grant), 32'h0);
    drive(4'b0101, 4'b0000, 1'b0, 32'h0052_0050);
    check_eq("t5_restart_grant", 32'(grant), 32'h1);
    check_eq("t5_restart_din",   32'(fifo_din), 32'h050);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
